// File: rtl/rtc_countdown_timer.sv
// rtc_countdown_timer: down-counting msec/sec/min/hour timer.
// Software loads a duration, then starts, pauses and clears the count.
// The timer counts down once per 100 ms tick and reports completion with a
// one-cycle o_done pulse and a held o_expired level.
module rtc_countdown_timer #(
  parameter int TICK_DIV = 10_000_000,
  parameter int CNT_W    = 24
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_clear,
  input  logic [7:0] i_msec,
  input  logic [7:0] i_sec,
  input  logic [7:0] i_min,
  input  logic [7:0] i_hour,
  output logic [7:0] o_msec,
  output logic [7:0] o_sec,
  output logic [7:0] o_min,
  output logic [7:0] o_hour,
  output logic       o_running,
  output logic       o_expired,
  output logic       o_done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

  // Clamp an out-of-range load value to the largest legal field value.
  function automatic logic [7:0] sat_field(input logic [7:0] val, input logic [7:0] max_val);
    logic [7:0] res;
    if (val > max_val) begin
      res = max_val;
    end else begin
      res = val;
    end
    return res;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [7:0]       msec_q, msec_d;
  logic [7:0]       sec_q, sec_d;
  logic [7:0]       min_q, min_d;
  logic [7:0]       hour_q, hour_d;
  logic             done_q, done_d;

  logic [7:0]       dec_msec_s, dec_sec_s, dec_min_s, dec_hour_s;
  logic             dec_zero_s;
  logic             time_zero_s;
  logic             tick_s;

  assign tick_s      = (state_q == ST_RUN) && (presc_q == TICK_MAX);
  assign time_zero_s = (msec_q == 8'd0) && (sec_q == 8'd0) &&
                       (min_q == 8'd0) && (hour_q == 8'd0);

  // Borrow-chain decrement of the current time by one tenth of a second.
  always_comb begin
    dec_msec_s = msec_q;
    dec_sec_s  = sec_q;
    dec_min_s  = min_q;
    dec_hour_s = hour_q;
    if (msec_q != 8'd0) begin
      dec_msec_s = msec_q - 8'd1;
    end else begin
      dec_msec_s = 8'd9;
      if (sec_q != 8'd0) begin
        dec_sec_s = sec_q - 8'd1;
      end else begin
        dec_sec_s = 8'd59;
        if (min_q != 8'd0) begin
          dec_min_s = min_q - 8'd1;
        end else begin
          dec_min_s  = 8'd59;
          dec_hour_s = hour_q - 8'd1;
        end
      end
    end
    dec_zero_s = (dec_msec_s == 8'd0) && (dec_sec_s == 8'd0) &&
                 (dec_min_s == 8'd0) && (dec_hour_s == 8'd0);
  end

  // Next-state, prescaler and field update; strobe priority clear > load > start > pause.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    msec_d  = msec_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    done_d  = 1'b0;

    if (i_clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
      msec_d  = 8'd0;
      sec_d   = 8'd0;
      min_d   = 8'd0;
      hour_d  = 8'd0;
    end else if (i_load && (state_q != ST_RUN)) begin
      state_d = ST_IDLE;
      presc_d = '0;
      msec_d  = sat_field(i_msec, 8'd9);
      sec_d   = sat_field(i_sec, 8'd59);
      min_d   = sat_field(i_min, 8'd59);
      hour_d  = sat_field(i_hour, 8'd23);
    end else if (!i_load && i_start &&
                 ((state_q == ST_IDLE) || (state_q == ST_PAUSE))) begin
      if (time_zero_s) begin
        state_d = ST_EXPIRED;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
        // A resume keeps the partial tick; a fresh start begins a full tick.
        if (state_q == ST_IDLE) begin
          presc_d = '0;
        end else begin
          presc_d = presc_q;
        end
      end
    end else if (!i_load && !i_start && i_pause && (state_q == ST_RUN)) begin
      state_d = ST_PAUSE;
    end else if (state_q == ST_RUN) begin
      if (tick_s) begin
        presc_d = '0;
        msec_d  = dec_msec_s;
        sec_d   = dec_sec_s;
        min_d   = dec_min_s;
        hour_d  = dec_hour_s;
        if (dec_zero_s) begin
          state_d = ST_EXPIRED;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end else begin
        presc_d = presc_q + CNT_W'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, prescaler, time fields and done pulse registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      msec_q  <= 8'd0;
      sec_q   <= 8'd0;
      min_q   <= 8'd0;
      hour_q  <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      msec_q  <= msec_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      done_q  <= done_d;
    end
  end

  assign o_msec    = msec_q;
  assign o_sec     = sec_q;
  assign o_min     = min_q;
  assign o_hour    = hour_q;
  assign o_running = (state_q == ST_RUN);
  assign o_expired = (state_q == ST_EXPIRED);
  assign o_done    = done_q;

endmodule

// File: tb/tb_rtc_countdown_timer.sv
// Directed bench for rtc_countdown_timer with TICK_DIV = 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rtc_countdown_timer;

  logic       clk;
  logic       rst;
  logic       load_s, start_s, pause_s, clear_s;
  logic [7:0] in_msec, in_sec, in_min, in_hour;
  logic [7:0] o_msec, o_sec, o_min, o_hour;
  logic       o_running, o_expired, o_done;

  int total_cnt;
  int bad_cnt;

  rtc_countdown_timer #(.TICK_DIV(4), .CNT_W(4)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_load   (load_s),
    .i_start  (start_s),
    .i_pause  (pause_s),
    .i_clear  (clear_s),
    .i_msec   (in_msec),
    .i_sec    (in_sec),
    .i_min    (in_min),
    .i_hour   (in_hour),
    .o_msec   (o_msec),
    .o_sec    (o_sec),
    .o_min    (o_min),
    .o_hour   (o_hour),
    .o_running(o_running),
    .o_expired(o_expired),
    .o_done   (o_done)
  );

  // Free-running 100 MHz-style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Packed view {hour, min, sec, msec} of the displayed time.
  function automatic logic [31:0] now_time();
    return {o_hour, o_min, o_sec, o_msec};
  endfunction

  function automatic logic [31:0] tv(input int h, input int m, input int s, input int ms);
    return {h[7:0], m[7:0], s[7:0], ms[7:0]};
  endfunction

  // Status view {running, expired, done}.
  function automatic logic [31:0] now_flags();
    return {29'd0, o_running, o_expired, o_done};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int h, input int m, input int s, input int ms);
    in_hour = h[7:0];
    in_min  = m[7:0];
    in_sec  = s[7:0];
    in_msec = ms[7:0];
    load_s  = 1'b1;
    @(negedge clk);
    load_s  = 1'b0;
  endtask

  task automatic do_start();
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
  endtask

  task automatic do_pause();
    pause_s = 1'b1;
    @(negedge clk);
    pause_s = 1'b0;
  endtask

  task automatic do_clear();
    clear_s = 1'b1;
    @(negedge clk);
    clear_s = 1'b0;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst = 1'b1;
    load_s = 1'b0; start_s = 1'b0; pause_s = 1'b0; clear_s = 1'b0;
    in_msec = 8'd0; in_sec = 8'd0; in_min = 8'd0; in_hour = 8'd0;
    cycles(2);
    check("reset_time", now_time(), tv(0, 0, 0, 0));
    check("reset_flags", now_flags(), 32'd0);
    rst = 1'b0;
    cycles(1);

    // 1: count 0.3 down to zero.
    do_load(0, 0, 0, 3);
    check("t1_loaded", now_time(), tv(0, 0, 0, 3));
    do_start();
    check("t1_running", now_flags(), 32'd4);
    cycles(3);
    check("t1_c3", now_time(), tv(0, 0, 0, 3));
    cycles(1);
    check("t1_c4", now_time(), tv(0, 0, 0, 2));
    cycles(4);
    check("t1_c8", now_time(), tv(0, 0, 0, 1));
    cycles(3);
    check("t1_c11_flags", now_flags(), 32'd4);
    cycles(1);
    check("t1_c12_time", now_time(), tv(0, 0, 0, 0));
    check("t1_c12_flags", now_flags(), 32'd3);
    cycles(1);
    check("t1_c13_flags", now_flags(), 32'd2);
    cycles(3);
    check("t1_hold_time", now_time(), tv(0, 0, 0, 0));

    // 2: borrow across hours and minutes.
    do_load(1, 0, 0, 0);
    check("t2_load_exp", now_flags(), 32'd0);
    do_start();
    cycles(4);
    check("t2_hour_borrow", now_time(), tv(0, 59, 59, 9));
    do_clear();
    check("t2_clear", now_time(), tv(0, 0, 0, 0));
    check("t2_clear_flags", now_flags(), 32'd0);
    do_load(0, 1, 0, 0);
    do_start();
    cycles(4);
    check("t2_min_borrow", now_time(), tv(0, 0, 59, 9));
    do_clear();

    // 3: pause freezes, resume keeps the partial tick.
    do_load(0, 0, 5, 0);
    do_start();
    cycles(6);
    check("t3_pre_pause", now_time(), tv(0, 0, 4, 9));
    do_pause();
    check("t3_paused_flags", now_flags(), 32'd0);
    cycles(20);
    check("t3_frozen", now_time(), tv(0, 0, 4, 9));
    do_start();
    check("t3_resumed", now_flags(), 32'd4);
    cycles(1);
    check("t3_r1", now_time(), tv(0, 0, 4, 9));
    cycles(1);
    check("t3_r2", now_time(), tv(0, 0, 4, 8));
    do_clear();

    // 4: saturation, then start with zero time.
    do_load(30, 60, 75, 12);
    check("t4_sat", now_time(), tv(23, 59, 59, 9));
    do_load(0, 0, 0, 0);
    do_start();
    check("t4_zero_start", now_flags(), 32'd3);
    cycles(1);
    check("t4_done_once", now_flags(), 32'd2);
    do_clear();

    // 5: clear beats load in RUN; load alone in RUN is ignored.
    do_load(0, 0, 2, 0);
    do_start();
    cycles(2);
    in_sec  = 8'd30;
    load_s  = 1'b1;
    clear_s = 1'b1;
    @(negedge clk);
    load_s  = 1'b0;
    clear_s = 1'b0;
    check("t5_clr_time", now_time(), tv(0, 0, 0, 0));
    check("t5_clr_flags", now_flags(), 32'd0);
    do_load(0, 0, 2, 0);
    do_start();
    cycles(2);
    do_load(0, 0, 50, 0);
    check("t5_ld_ignored", now_time(), tv(0, 0, 2, 0));
    check("t5_still_run", now_flags(), 32'd4);
    cycles(1);
    check("t5_counting", now_time(), tv(0, 0, 1, 9));
    do_clear();

    // 6: asynchronous reset mid-run.
    do_load(0, 0, 2, 5);
    do_start();
    cycles(4);
    check("t6_pre_rst", now_time(), tv(0, 0, 2, 4));
    #2 rst = 1'b1;
    #1;
    check("t6_async_time", now_time(), tv(0, 0, 0, 0));
    check("t6_async_flags", now_flags(), 32'd0);
    cycles(2);
    rst = 1'b0;
    cycles(1);
    check("t6_idle_flags", now_flags(), 32'd0);
    do_load(0, 0, 0, 1);
    do_start();
    cycles(3);
    check("t6_presc_c3", now_flags(), 32'd4);
    cycles(1);
    check("t6_presc_c4", now_flags(), 32'd3);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
